// File: rtl/aes_dec_round_ctrl.sv
// AES decryption round sequencer: steps the datapath through the initial
// key add, NR-1 full inverse rounds, the final round and the output hold.
module aes_dec_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_ready,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       load_en,
  output logic       round_en,
  output logic       imc_en,
  output logic [3:0] rk_idx,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_e;

  localparam logic [3:0] NR4 = 4'(NR);
  localparam logic [3:0] NR1 = 4'(NR - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rk_q, rk_d;
  logic       round_q, round_d;
  logic       imc_q, imc_d;
  logic       ov_q, ov_d;
  logic       busy_q, busy_d;
  logic       accept;

  assign in_ready = key_ready & (state_q == IDLE);
  assign load_en  = in_valid & in_ready;
  assign accept   = load_en;

  assign out_valid = ov_q;
  assign round_en  = round_q;
  assign imc_en    = imc_q;
  assign rk_idx    = rk_q;
  assign busy      = busy_q;

  // Outputs are computed for the state being entered, so they are registered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rk_d    = NR4;
    round_d = 1'b0;
    imc_d   = 1'b0;
    ov_d    = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ROUND;
          cnt_d   = NR1;
          rk_d    = NR1;
          round_d = 1'b1;
          imc_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ROUND: begin
        busy_d  = 1'b1;
        round_d = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
        if (cnt_q <= 4'd1) begin
          state_d = FINAL;
          rk_d    = 4'd0;
        end else begin
          imc_d = 1'b1;
          rk_d  = cnt_q - 4'd1;
        end
      end
      FINAL: begin
        state_d = DONE;
        ov_d    = 1'b1;
        busy_d  = 1'b1;
        rk_d    = 4'd0;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          ov_d   = 1'b1;
          busy_d = 1'b1;
          rk_d   = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rk_q    <= NR4;
      round_q <= 1'b0;
      imc_q   <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      imc_q   <= imc_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: NR=10 and NR=14 instances share stimulus,
// directed scenarios plus a random run against an age-based block model.
module tb_aes_dec_round_ctrl;

  localparam int NRS[2] = '{10, 14};

  typedef struct packed {
    logic       ir;
    logic       le;
    logic       re;
    logic       ie;
    logic       ov;
    logic       bz;
    logic [3:0] rk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_ready;
  logic       in_valid;
  logic       out_ready;
  logic       ir[2];
  logic       ov[2];
  logic       le[2];
  logic       re[2];
  logic       ie[2];
  logic       bz[2];
  logic [3:0] rk[2];

  int checks = 0;
  int errors = 0;
  int a_checks = 0;
  int a_errors = 0;

  bit act[2];
  int age[2];

  always #5 clk = ~clk;

  aes_dec_round_ctrl #(.NR(10)) dut10 (
    .clk(clk), .rst(rst), .key_ready(key_ready),
    .in_valid(in_valid), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_ready(out_ready),
    .load_en(le[0]), .round_en(re[0]), .imc_en(ie[0]),
    .rk_idx(rk[0]), .busy(bz[0])
  );

  aes_dec_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .key_ready(key_ready),
    .in_valid(in_valid), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_ready(out_ready),
    .load_en(le[1]), .round_en(re[1]), .imc_en(ie[1]),
    .rk_idx(rk[1]), .busy(bz[1])
  );

  // Block model: age counts cycles since acceptance
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] <= 1'b0;
        age[i] <= 0;
      end else if (!act[i]) begin
        if (in_valid && key_ready) begin
          act[i] <= 1'b1;
          age[i] <= 1;
        end
      end else if (age[i] > NRS[i]) begin
        if (out_ready) act[i] <= 1'b0;
      end else begin
        age[i] <= age[i] + 1;
      end
    end
  end

  function automatic exp_t model(int i);
    exp_t e;
    int n = NRS[i];
    e = '{ir: 1'b0, le: 1'b0, re: 1'b0, ie: 1'b0,
          ov: 1'b0, bz: 1'b0, rk: 4'(n)};
    if (!act[i]) begin
      e.ir = key_ready;
      e.le = key_ready & in_valid;
    end else if (age[i] < n) begin
      e.re = 1'b1;
      e.ie = 1'b1;
      e.bz = 1'b1;
      e.rk = 4'(n - age[i]);
    end else if (age[i] == n) begin
      e.re = 1'b1;
      e.bz = 1'b1;
      e.rk = 4'd0;
    end else begin
      e.ov = 1'b1;
      e.bz = 1'b1;
      e.rk = 4'd0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      a_checks += 3;
      assert (!(le[i] && re[i])) else begin
        a_errors++;
        $display("FAIL excl_en nr=%0d le=%b re=%b", NRS[i], le[i], re[i]);
      end
      assert (int'(rk[i]) <= NRS[i]) else begin
        a_errors++;
        $display("FAIL rk_range nr=%0d rk=%0d", NRS[i], rk[i]);
      end
      assert (!(ov[i] && ir[i])) else begin
        a_errors++;
        $display("FAIL ov_ir nr=%0d ov=%b ir=%b", NRS[i], ov[i], ir[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_ready = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({ov[i], le[i], re[i], ie[i], bz[i], rk[i]}
          !== {5'b0, 4'(NRS[i])}) begin
        errors++;
        $display("FAIL reset_outs nr=%0d got=%b want=%b", NRS[i],
                 {ov[i], le[i], re[i], ie[i], bz[i], rk[i]},
                 {5'b0, 4'(NRS[i])});
      end
    end
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ir[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ir_hi nr=%0d got=%b want=1", NRS[i], ir[i]);
      end
    end
    key_ready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ir[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ir_lo nr=%0d got=%b want=0", NRS[i], ir[i]);
      end
    end
    key_ready = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int n = NRS[i];
        exp_t e;
        e.le = (k == 0);
        e.re = (k >= 1 && k <= n);
        e.ie = (k >= 1 && k < n);
        e.ov = (k == n + 1);
        e.bz = (k >= 1 && k <= n + 1);
        e.ir = !(k >= 1 && k <= n + 1);
        if (k >= 1 && k < n) e.rk = 4'(n - k);
        else if (k == n || k == n + 1) e.rk = 4'd0;
        else e.rk = 4'(n);
        checks++;
        if ({ir[i], le[i], re[i], ie[i], ov[i], bz[i], rk[i]} !== e) begin
          errors++;
          $display("FAIL latency nr=%0d k=%0d got=%b want=%b", n, k,
                   {ir[i], le[i], re[i], ie[i], ov[i], bz[i], rk[i]}, e);
        end
      end
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ov[i] !== (k >= NRS[i] + 1) || ir[i] !== (k == 0) ||
            bz[i] !== (k >= 1)) begin
          errors++;
          $display("FAIL hold nr=%0d k=%0d ov=%b ir=%b busy=%b",
                   NRS[i], k, ov[i], ir[i], bz[i]);
        end
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ov[i] !== 1'b1 || ir[i] !== 1'b0) begin
        errors++;
        $display("FAIL hold_last nr=%0d ov=%b ir=%b want ov=1 ir=0",
                 NRS[i], ov[i], ir[i]);
      end
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || ir[i] !== 1'b1 || bz[i] !== 1'b0) begin
        errors++;
        $display("FAIL release nr=%0d ov=%b ir=%b busy=%b want 0 1 0",
                 NRS[i], ov[i], ir[i], bz[i]);
      end
    end
    tick();
  endtask

  task automatic test_key_gate();
    key_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({ir[i], le[i], bz[i], rk[i]} !== {3'b0, 4'(NRS[i])}) begin
          errors++;
          $display("FAIL key_gate nr=%0d got=%b want=%b", NRS[i],
                   {ir[i], le[i], bz[i], rk[i]}, {3'b0, 4'(NRS[i])});
        end
      end
      tick();
    end
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    in_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ov[i] !== (k == NRS[i] + 1) ||
            bz[i] !== (k <= NRS[i] + 1)) begin
          errors++;
          $display("FAIL key_drop nr=%0d k=%0d ov=%b busy=%b",
                   NRS[i], k, ov[i], bz[i]);
        end
      end
      tick();
    end
    key_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k <= 25; k++) begin
      rst = (k == 5);
      in_valid = (k == 0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (k == 6) begin
          checks++;
          if ({le[i], re[i], ie[i], bz[i], rk[i]}
              !== {4'b0, 4'(NRS[i])}) begin
            errors++;
            $display("FAIL mid_rst nr=%0d got=%b want=%b", NRS[i],
                     {le[i], re[i], ie[i], bz[i], rk[i]},
                     {4'b0, 4'(NRS[i])});
          end
        end
        if (k >= 6) begin
          checks++;
          if (ov[i] !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_ov nr=%0d k=%0d got=%b want=0",
                     NRS[i], k, ov[i]);
          end
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    key_ready = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (le[i] !== (k % (NRS[i] + 2) == 0)) begin
          errors++;
          $display("FAIL b2b nr=%0d k=%0d load_en=%b want=%b", NRS[i],
                   k, le[i], (k % (NRS[i] + 2) == 0));
        end
      end
      tick();
    end
    in_valid = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_random();
    exp_t e;
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      key_ready = ($urandom_range(0, 9) != 0);
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        e = model(i);
        checks++;
        if ({ir[i], le[i], re[i], ie[i], ov[i], bz[i], rk[i]} !== e) begin
          errors++;
          $display("FAIL random nr=%0d c=%0d got=%b want=%b", NRS[i], c,
                   {ir[i], le[i], re[i], ie[i], ov[i], bz[i], rk[i]}, e);
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_key_gate();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    checks += a_checks;
    errors += a_errors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_dec_round_ctrl.md
AES_DEC_ROUND_CTRL -- requirements
Module: aes_dec_round_ctrl

Interface
REQ-001 Parameter: NR, default 10, number of cipher rounds; legal values 10, 12 and 14.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: key_ready  input  1  high when the expanded round-key store holds valid keys 0..NR.
REQ-005 Port: in_valid  input  1  a ciphertext block is presented to the datapath.
REQ-006 Port: in_ready  output  1  controller accepts a block this cycle.
REQ-007 Port: out_valid  output  1  the datapath state register holds a finished plaintext.
REQ-008 Port: out_ready  input  1  downstream consumes the plaintext.
REQ-009 Port: load_en  output  1  datapath state register loads ciphertext XOR rk[rk_idx].
REQ-010 Port: round_en  output  1  datapath state register loads the result of one inverse round.
REQ-011 Port: imc_en  output  1  1 = InvMixColumns applied; 0 = bypass (final round).
REQ-012 Port: rk_idx  output  4  round-key read index into the key store.
REQ-013 Port: busy  output  1  high from the cycle after acceptance until the cycle before out_valid rises, plus every out_valid cycle.

Function
REQ-014 FSM states: IDLE, ROUND, FINAL, DONE; encoding is free.
REQ-015 IDLE: in_ready = key_ready; rk_idx = NR; load_en = in_valid & in_ready; round_en = 0; imc_en = 0.
REQ-016 IDLE -> ROUND on in_valid & in_ready (acceptance cycle T); the round counter loads NR-1.
REQ-017 ROUND: round_en = 1; imc_en = 1; rk_idx = counter; the counter decrements each cycle.
REQ-018 ROUND -> FINAL in the cycle where counter == 1 (after NR-1 ROUND cycles, keys NR-1 down to 1).
REQ-019 FINAL (one cycle): round_en = 1; imc_en = 0; rk_idx = 0; then -> DONE.
REQ-020 DONE: out_valid = 1; all enables 0; rk_idx = 0; the state is held while out_ready = 0.
REQ-021 DONE -> IDLE on out_ready; in_ready is 0 in DONE, so there is no same-cycle re-accept.
REQ-022 Latency: acceptance at cycle T gives out_valid = 1 first at T+NR+1 (T+11 for NR = 10).
REQ-023 Throughput: at most one block per NR+2 cycles with out_ready held high.
REQ-024 in_ready = 0 in ROUND, FINAL and DONE; in_valid in those states is ignored.
REQ-025 key_ready dropping while not in IDLE has no effect on the current block; it gates new acceptance only.
REQ-026 Exactly one of load_en and round_en is high in any cycle where either is high; both are 0 in DONE and in idle cycles.
REQ-027 The round counter is 4 bits and never wraps below 0; rk_idx is always in 0..NR.
REQ-028 All outputs are decoded from the state and counter (Moore), except load_en and in_ready, which depend combinationally on in_valid and key_ready.

Reset
REQ-029 rst = 1 at a clock edge forces IDLE and counter = 0, overriding every other input, including mid-ROUND or in DONE.
REQ-030 During and after reset: out_valid = 0, load_en = 0, round_en = 0, imc_en = 0, busy = 0, rk_idx = NR; in_ready follows key_ready from the first cycle after rst deasserts.
REQ-031 A block in flight at reset is discarded; no out_valid is produced for it.

Verification
REQ-032 NR = 10, key_ready = 1, in_valid pulse at T, out_ready = 1 -> load_en at T; round_en T+1..T+10; rk_idx 9,8,...,1 then 0; imc_en = 0 only at T+10; out_valid at T+11 for 1 cycle; in_ready = 1 at T+12.
REQ-033 out_ready = 0 for 5 cycles after out_valid rises -> out_valid and busy held for 5 cycles, in_ready = 0, in_valid ignored; IDLE on the cycle after out_ready = 1.
REQ-034 key_ready = 0 with in_valid = 1 -> in_ready = 0, load_en = 0, and the state remains IDLE.
REQ-035 rst asserted at T+5 of a block -> next cycle: IDLE, all enables 0, rk_idx = 10; out_valid never rises for that block.
REQ-036 NR = 14 back-to-back blocks with out_ready = 1 -> out_valid at T+15; second acceptance at T+16; rk_idx sequence 13..1, then 0.
REQ-037 Assertions active for the full simulation: load_en & round_en never high together; rk_idx <= NR; out_valid implies in_ready = 0.
